// File: rtl/io_pkg.sv
// Shared constants for io_port_bank: status word bit positions and FIFO count width.
package io_pkg;

  localparam int ST_IN_EMPTY    = 0;
  localparam int ST_IN_FULL     = 1;
  localparam int ST_OUT_EMPTY   = 2;
  localparam int ST_OUT_FULL    = 3;
  localparam int ST_IN_OVF      = 4;
  localparam int ST_IN_UNF      = 5;
  localparam int ST_OUT_OVF     = 6;
  localparam int ST_IN_CNT_LSB  = 8;
  localparam int ST_OUT_CNT_LSB = 16;

  // Occupancy must represent DEPTH itself, hence one bit wider than the pointers.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/port_fifo.sv
// Show-ahead FIFO, head visible the cycle after the push edge; zero on dout when empty.
// Push while full is taken only if a pop frees the slot in the same cycle; pop while empty is ignored.
module port_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_bank.sv
// Multi-channel I/O bank: per-channel input/output FIFOs, sticky error flags, bus mux and irq.
// Bus read data is combinational from state; external strobe/ack never reach an output combinationally.
module io_port_bank
  import io_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [SELW-1:0]           port_sel,
  input  logic                      in_read,
  input  logic                      status_read,
  input  logic                      out_write,
  input  logic [WIDTH-1:0]          bus_in,
  output logic [WIDTH-1:0]          bus_rdata,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_strobe,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ack,
  output logic                      irq
);

  localparam int CW = count_w(DEPTH);

  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic [CHANNELS-1:0] w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic [CHANNELS-1:0] w_in_ovf_ev, w_in_unf_ev, w_out_ovf_ev, w_st_clr;
  logic [CHANNELS-1:0] r_in_ovf, r_in_unf, r_out_ovf;
  logic [WIDTH-1:0]    w_in_dout  [CHANNELS];
  logic [WIDTH-1:0]    w_out_dout [CHANNELS];
  logic [CW-1:0]       w_in_cnt   [CHANNELS];
  logic [CW-1:0]       w_out_cnt  [CHANNELS];
  logic [WIDTH-1:0]    w_status   [CHANNELS];

  // Out-of-range selects match no channel, so bus ops become no-ops returning 0.
  always_comb begin
    w_sel        = '0;
    w_in_push    = '0;
    w_in_pop     = '0;
    w_out_push   = '0;
    w_out_pop    = '0;
    w_in_ovf_ev  = '0;
    w_in_unf_ev  = '0;
    w_out_ovf_ev = '0;
    w_st_clr     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_sel[c]        = (port_sel == SELW'(c));
      w_in_push[c]    = in_strobe[c] & ~w_in_full[c];
      w_in_ovf_ev[c]  = in_strobe[c] & w_in_full[c];
      w_in_pop[c]     = w_sel[c] & in_read & ~status_read & ~w_in_empty[c];
      w_in_unf_ev[c]  = w_sel[c] & in_read & ~status_read & w_in_empty[c];
      w_out_pop[c]    = out_ack[c] & ~w_out_empty[c];
      w_out_push[c]   = w_sel[c] & out_write & (~w_out_full[c] | w_out_pop[c]);
      w_out_ovf_ev[c] = w_sel[c] & out_write & w_out_full[c] & ~w_out_pop[c];
      w_st_clr[c]     = w_sel[c] & status_read;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (w_in_push[c]),
      .pop   (w_in_pop[c]),
      .din   (in_data[c*WIDTH +: WIDTH]),
      .dout  (w_in_dout[c]),
      .count (w_in_cnt[c]),
      .full  (w_in_full[c]),
      .empty (w_in_empty[c])
    );

    port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (w_out_push[c]),
      .pop   (w_out_pop[c]),
      .din   (bus_in),
      .dout  (w_out_dout[c]),
      .count (w_out_cnt[c]),
      .full  (w_out_full[c]),
      .empty (w_out_empty[c])
    );

    assign out_data[c*WIDTH +: WIDTH] = w_out_dout[c];
  end

  assign in_ready  = ~w_in_full;
  assign out_valid = ~w_out_empty;
  assign irq       = (|(~w_in_empty)) | (|r_in_ovf) | (|r_in_unf) | (|r_out_ovf);

  // A same-cycle error event outranks the clear-on-read.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_in_ovf  <= '0;
      r_in_unf  <= '0;
      r_out_ovf <= '0;
    end else begin
      r_in_ovf  <= (r_in_ovf  & ~w_st_clr) | w_in_ovf_ev;
      r_in_unf  <= (r_in_unf  & ~w_st_clr) | w_in_unf_ev;
      r_out_ovf <= (r_out_ovf & ~w_st_clr) | w_out_ovf_ev;
    end
  end

  always_comb begin
    bus_rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_status[c]                            = '0;
      w_status[c][ST_IN_EMPTY]               = w_in_empty[c];
      w_status[c][ST_IN_FULL]                = w_in_full[c];
      w_status[c][ST_OUT_EMPTY]              = w_out_empty[c];
      w_status[c][ST_OUT_FULL]               = w_out_full[c];
      w_status[c][ST_IN_OVF]                 = r_in_ovf[c];
      w_status[c][ST_IN_UNF]                 = r_in_unf[c];
      w_status[c][ST_OUT_OVF]                = r_out_ovf[c];
      w_status[c][ST_IN_CNT_LSB +: CW]       = w_in_cnt[c];
      w_status[c][ST_OUT_CNT_LSB +: CW]      = w_out_cnt[c];
      if (w_sel[c]) begin
        bus_rdata = status_read ? w_status[c] : w_in_dout[c];
      end
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed test-plan cases with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of the channel FIFOs and sticky flags.
module tb_io_port_bank;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 4;

  logic                      clk = 1'b0;
  logic                      clr;
  logic [0:0]                port_sel;
  logic                      in_read;
  logic                      status_read;
  logic                      out_write;
  logic [WIDTH-1:0]          bus_in;
  logic [WIDTH-1:0]          bus_rdata;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_strobe;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ack;
  logic                      irq;

  always #5 clk = ~clk;

  io_port_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clr         (clr),
    .port_sel    (port_sel),
    .in_read     (in_read),
    .status_read (status_read),
    .out_write   (out_write),
    .bus_in      (bus_in),
    .bus_rdata   (bus_rdata),
    .in_data     (in_data),
    .in_strobe   (in_strobe),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .irq         (irq)
  );

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  logic [WIDTH-1:0] m_in  [CHANNELS][$];
  logic [WIDTH-1:0] m_out [CHANNELS][$];
  bit m_iovf [CHANNELS];
  bit m_iunf [CHANNELS];
  bit m_oovf [CHANNELS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_in_head(input int c);
    return (m_in[c].size() > 0) ? m_in[c][0] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] m_out_head(input int c);
    return (m_out[c].size() > 0) ? m_out[c][0] : '0;
  endfunction

  function automatic logic [31:0] m_status(input int c);
    int isz = m_in[c].size();
    int osz = m_out[c].size();
    return {8'h00, 8'(osz), 8'(isz), 1'b0, m_oovf[c], m_iunf[c], m_iovf[c],
            (osz == DEPTH), (osz == 0), (isz == DEPTH), (isz == 0)};
  endfunction

  // Reference model: advances on each rising edge from the inputs the bench is driving.
  always @(posedge clk) begin : model
    int  isz, osz;
    bit  sel, opop;
    if (clr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m_in[c].delete();
        m_out[c].delete();
        m_iovf[c] = 0;
        m_iunf[c] = 0;
        m_oovf[c] = 0;
      end
      started = 1;
    end else if (started) begin
      for (int c = 0; c < CHANNELS; c++) begin
        isz  = m_in[c].size();
        osz  = m_out[c].size();
        sel  = (int'(port_sel) == c);
        opop = out_ack[c] && (osz > 0);
        if (sel && status_read) begin
          m_iovf[c] = 0;
          m_iunf[c] = 0;
          m_oovf[c] = 0;
        end
        if (sel && in_read && !status_read) begin
          if (isz > 0) void'(m_in[c].pop_front());
          else m_iunf[c] = 1;
        end
        if (in_strobe[c]) begin
          if (isz < DEPTH) m_in[c].push_back(in_data[c*WIDTH +: WIDTH]);
          else m_iovf[c] = 1;
        end
        if (opop) void'(m_out[c].pop_front());
        if (sel && out_write) begin
          if (osz < DEPTH || opop) m_out[c].push_back(bus_in);
          else m_oovf[c] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [CHANNELS-1:0]       e_rdy, e_vld;
    logic [CHANNELS*WIDTH-1:0] e_dat;
    logic                      e_irq;
    if (started) begin
      e_irq = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        e_rdy[c] = (m_in[c].size() < DEPTH);
        e_vld[c] = (m_out[c].size() > 0);
        e_dat[c*WIDTH +: WIDTH] = m_out_head(c);
        e_irq = e_irq | (m_in[c].size() > 0) | m_iovf[c] | m_iunf[c] | m_oovf[c];
      end
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      chk("out_valid", 64'(out_valid), 64'(e_vld));
      chk("out_data", out_data, e_dat);
      chk("irq", 64'(irq), 64'(e_irq));
      if (status_read) chk("bus_status", 64'(bus_rdata), 64'(m_status(int'(port_sel))));
      else if (in_read) chk("bus_pop", 64'(bus_rdata), 64'(m_in_head(int'(port_sel))));
    end
  end

  task automatic idle();
    clr = 0; port_sel = 0; in_read = 0; status_read = 0; out_write = 0;
    bus_in = '0; in_data = '0; in_strobe = '0; out_ack = '0;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int mode;
    idle();
    clr = 1;
    go();
    idle();

    // reset state
    status_read = 1; port_sel = 0;
    look();
    chk("rst_status", 64'(bus_rdata), 64'h5);
    chk("rst_in_ready", 64'(in_ready), 64'h3);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    go();
    idle();

    // fill ch1 past full
    for (int i = 0; i < 5; i++) begin
      in_strobe = 2'b10;
      in_data[63:32] = 32'hA0 + 32'(i);
      if (i == 4) begin
        look();
        chk("full_in_ready1", 64'(in_ready[1]), 64'h0);
      end
      go();
    end
    idle();
    status_read = 1; port_sel = 1;
    look();
    chk("ovf_status", 64'(bus_rdata), 64'h416);
    go();
    look();
    chk("ovf_cleared", 64'(bus_rdata), 64'h406);
    go();
    idle();

    // drain ch1 and underflow
    port_sel = 1; in_read = 1;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("drain", 64'(bus_rdata), 64'hA0 + 64'(i));
      go();
    end
    look();
    chk("unf_read", 64'(bus_rdata), 64'h0);
    go();
    idle();
    status_read = 1; port_sel = 1;
    look();
    chk("unf_status", 64'(bus_rdata), 64'h25);
    go();
    idle();

    // output wrap-around with ack held
    port_sel = 0; out_ack = 2'b01; out_write = 1;
    for (int i = 0; i < 10; i++) begin
      bus_in = 32'(i + 1);
      look();
      chk("wrap_data", 64'(out_data[31:0]), 64'(i));
      go();
    end
    out_write = 0;
    look();
    chk("wrap_last", 64'(out_data[31:0]), 64'hA);
    go();
    idle();
    status_read = 1; port_sel = 0;
    look();
    chk("wrap_status", 64'(bus_rdata), 64'h5);
    go();
    idle();

    // full output FIFO with and without simultaneous ack
    port_sel = 0; out_write = 1;
    for (int i = 0; i < 4; i++) begin
      bus_in = 32'h10 + 32'(i);
      go();
    end
    bus_in = 32'h55; out_ack = 2'b01;
    go();
    out_ack = 0; out_write = 0; status_read = 1;
    look();
    chk("full_ack_status", 64'(bus_rdata), 64'h4_0009);
    chk("full_ack_head", 64'(out_data[31:0]), 64'h11);
    go();
    status_read = 0; out_write = 1; bus_in = 32'h66;
    go();
    out_write = 0; status_read = 1;
    look();
    chk("full_drop_status", 64'(bus_rdata), 64'h4_0049);
    go();
    idle();

    // reset mid-operation
    out_ack = 2'b01;
    repeat (4) go();
    idle();
    for (int i = 0; i < 6; i++) begin
      in_strobe = (i < 3) ? 2'b11 : 2'b00;
      in_data = {$urandom, $urandom};
      out_write = 1; port_sel = (i < 3) ? 1'b0 : 1'b1;
      bus_in = $urandom;
      go();
    end
    idle();
    look();
    chk("pre_clr_valid", 64'(out_valid), 64'h3);
    chk("pre_clr_irq", 64'(irq), 64'h1);
    go();
    clr = 1; in_strobe = 2'b11; in_data = {32'hDEAD0001, 32'hDEAD0000};
    go();
    idle();
    status_read = 1; port_sel = 0;
    look();
    chk("clr_status0", 64'(bus_rdata), 64'h5);
    chk("clr_irq", 64'(irq), 64'h0);
    chk("clr_in_ready", 64'(in_ready), 64'h3);
    go();
    port_sel = 1;
    look();
    chk("clr_status1", 64'(bus_rdata), 64'h5);
    go();
    idle();

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 3000; n++) begin
      mode = (n / 150) % 2;
      clr = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < CHANNELS; c++) begin
        in_strobe[c] = ($urandom_range(0, 3) < ((mode == 0) ? 3 : 1));
        out_ack[c]   = ($urandom_range(0, 3) < ((mode == 0) ? 1 : 3));
      end
      in_data     = {$urandom, $urandom};
      port_sel    = 1'($urandom);
      bus_in      = $urandom;
      status_read = ($urandom_range(0, 7) == 0);
      in_read     = ($urandom_range(0, 3) < ((mode == 0) ? 1 : 3));
      out_write   = ($urandom_range(0, 3) < ((mode == 0) ? 3 : 1));
      go();
    end
    idle();
    go();
    look();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
